// File: rtl/frame_mask_stats_pkg.sv
// Shared definitions for the frame mask statistics stage: FSM encodings,
// coordinate width and the sync-path latency helper.
package frame_mask_stats_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [2:0] {
    ACC_SYNC   = 3'b001,
    ACC_WAIT   = 3'b010,
    ACC_ACTIVE = 3'b100
  } acc_state_t;

  typedef enum logic [2:0] {
    NRM_IDLE  = 3'b001,
    NRM_NORM  = 3'b010,
    NRM_LATCH = 3'b100
  } nrm_state_t;

  // Sync delay: worst-case normalisation plus margin so operands settle first.
  function automatic int sync_latency(input int sw, input int n);
    return sw - n + 3;
  endfunction

endpackage

// File: rtl/frame_mask_stats_normalizer.sv
// Frame-end normaliser: shifts the snapshot right until the sum fits N bits,
// then latches divider operands and frame statistics. Bbox ports need STATS_BBOX_EN.
module stats_normalizer
  import frame_mask_stats_pkg::*;
#(
  parameter int CW = 20,
  parameter int SW = 28,
  parameter int N  = 16
) (
  input  logic               pixelclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CW-1:0]      snap_count,
  input  logic [SW-1:0]      snap_sum,
`ifdef STATS_BBOX_EN
  input  logic [COORD_W-1:0] snap_xmin,
  input  logic [COORD_W-1:0] snap_xmax,
  input  logic [COORD_W-1:0] snap_ymin,
  input  logic [COORD_W-1:0] snap_ymax,
  output logic [COORD_W-1:0] o_xmin,
  output logic [COORD_W-1:0] o_xmax,
  output logic [COORD_W-1:0] o_ymin,
  output logic [COORD_W-1:0] o_ymax,
`endif
  output logic               busy,
  output logic [N-1:0]       o_dividend,
  output logic [N-1:0]       o_divisor,
  output logic [4:0]         o_shift,
  output logic [CW-1:0]      o_count,
  output logic               o_empty,
  output logic               o_stat_valid
);

  nrm_state_t state_reg, state_next;

  logic [SW-1:0] sum_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] raw_cnt_reg;
  logic [4:0]    shift_reg;
  logic          fits;
  logic          load_en;
  logic          latch_en;
  logic          raw_empty;
  logic [N-1:0]  divisor_calc;

  assign fits      = (sum_reg[SW-1:N] == '0);
  assign load_en   = (state_reg == NRM_IDLE) && start;
  assign latch_en  = (state_reg == NRM_NORM) && fits;
  assign raw_empty = (raw_cnt_reg == '0);

  assign busy         = (state_reg != NRM_IDLE);
  // Operands are registered on entry to LATCH, so the pulse marks them valid.
  assign o_stat_valid = (state_reg == NRM_LATCH);

  always_comb begin
    divisor_calc = cnt_reg[N-1:0];
    if (cnt_reg[CW-1:N] != '0) begin
      divisor_calc = '1;
    end else if ((cnt_reg == '0) && !raw_empty) begin
      divisor_calc = N'(1);
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      state_reg <= NRM_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NRM_IDLE:  if (start) state_next = NRM_NORM;
      NRM_NORM:  if (fits) state_next = NRM_LATCH;
      NRM_LATCH: state_next = NRM_IDLE;
      default:   state_next = NRM_IDLE;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      sum_reg     <= '0;
      cnt_reg     <= '0;
      raw_cnt_reg <= '0;
      shift_reg   <= '0;
      o_dividend  <= '0;
      o_divisor   <= '0;
      o_shift     <= '0;
      o_count     <= '0;
      o_empty     <= 1'b0;
    end else begin
      if (load_en) begin
        sum_reg     <= snap_sum;
        cnt_reg     <= snap_count;
        raw_cnt_reg <= snap_count;
        shift_reg   <= '0;
      end else if ((state_reg == NRM_NORM) && !fits) begin
        sum_reg   <= sum_reg >> 1;
        cnt_reg   <= cnt_reg >> 1;
        shift_reg <= shift_reg + 5'd1;
      end
      if (latch_en) begin
        o_dividend <= sum_reg[N-1:0];
        o_divisor  <= divisor_calc;
        o_shift    <= shift_reg;
        o_count    <= raw_cnt_reg;
        o_empty    <= raw_empty;
      end
    end
  end

`ifdef STATS_BBOX_EN
  logic [COORD_W-1:0] xmin_reg, xmax_reg, ymin_reg, ymax_reg;

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      xmin_reg <= '0;
      xmax_reg <= '0;
      ymin_reg <= '0;
      ymax_reg <= '0;
      o_xmin   <= '0;
      o_xmax   <= '0;
      o_ymin   <= '0;
      o_ymax   <= '0;
    end else begin
      if (load_en) begin
        xmin_reg <= snap_xmin;
        xmax_reg <= snap_xmax;
        ymin_reg <= snap_ymin;
        ymax_reg <= snap_ymax;
      end
      // An empty frame leaves min at all-ones; report a zero box instead.
      if (latch_en) begin
        o_xmin <= raw_empty ? '0 : xmin_reg;
        o_xmax <= raw_empty ? '0 : xmax_reg;
        o_ymin <= raw_empty ? '0 : ymin_reg;
        o_ymax <= raw_empty ? '0 : ymax_reg;
      end
    end
  end
`endif

endmodule

// File: rtl/frame_mask_stats.sv
// Per-frame foreground count/sum accumulator feeding the frame-end divider.
// Define STATS_BBOX_EN to build the foreground bounding-box trackers.
module frame_mask_stats
  import frame_mask_stats_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int DW    = 8,
  parameter int CW    = 20,
  parameter int SW    = 28,
  parameter int N     = 16
) (
  input  logic               pixelclk,
  input  logic               rst_n,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic               i_mask,
  input  logic [DW-1:0]      i_value,
  output logic [N-1:0]       o_dividend,
  output logic [N-1:0]       o_divisor,
  output logic [4:0]         o_shift,
  output logic [CW-1:0]      o_count,
  output logic               o_empty,
  output logic [COORD_W-1:0] o_xmin,
  output logic [COORD_W-1:0] o_xmax,
  output logic [COORD_W-1:0] o_ymin,
  output logic [COORD_W-1:0] o_ymax,
  output logic               o_stat_valid,
  output logic               o_overrun,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de
);

  localparam int LAT = sync_latency(SW, N);

  acc_state_t acc_state_reg, acc_state_next;

  logic          vs_r;
  logic          vs_rise;
  logic          vs_fall;
  logic          acc_clear;
  logic          pix;
  logic          snap;
  logic          nrm_start;
  logic          nrm_busy;
  logic          overrun_reg;
  logic [CW-1:0] count_reg;
  logic [SW-1:0] sum_reg;
  logic [SW:0]   sum_ext;

  logic [LAT-1:0][2:0] sync_dly_reg;

  assign vs_rise   = i_vs & ~vs_r;
  assign vs_fall   = ~i_vs & vs_r;
  // Snapshot and clear share the fall cycle, so the fall-cycle pixel is not counted.
  assign acc_clear = (acc_state_reg != ACC_ACTIVE) | vs_fall;
  assign pix       = (acc_state_reg == ACC_ACTIVE) & i_de & i_mask;
  assign snap      = (acc_state_reg == ACC_ACTIVE) & vs_fall;
  assign nrm_start = snap & ~nrm_busy;
  assign sum_ext   = {1'b0, sum_reg} + (SW+1)'(i_value);

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      vs_r          <= 1'b0;
      acc_state_reg <= ACC_SYNC;
      overrun_reg   <= 1'b0;
    end else begin
      vs_r          <= i_vs;
      acc_state_reg <= acc_state_next;
      overrun_reg   <= snap & nrm_busy;
    end
  end

  always_comb begin
    acc_state_next = acc_state_reg;
    case (acc_state_reg)
      ACC_SYNC:   if (vs_fall) acc_state_next = ACC_WAIT;
      ACC_WAIT:   if (vs_rise) acc_state_next = ACC_ACTIVE;
      ACC_ACTIVE: if (vs_fall) acc_state_next = ACC_WAIT;
      default:    acc_state_next = ACC_SYNC;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      count_reg <= '0;
      sum_reg   <= '0;
    end else if (acc_clear) begin
      count_reg <= '0;
      sum_reg   <= '0;
    end else if (pix) begin
      count_reg <= (&count_reg) ? count_reg : count_reg + CW'(1);
      sum_reg   <= sum_ext[SW] ? '1 : sum_ext[SW-1:0];
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      sync_dly_reg <= '0;
    end else begin
      sync_dly_reg <= {sync_dly_reg[LAT-2:0], {i_hs, i_vs, i_de}};
    end
  end

  assign {o_hsync, o_vsync, o_de} = sync_dly_reg[LAT-1];
  assign o_overrun = overrun_reg;

`ifdef STATS_BBOX_EN
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACT - 1);

  logic               de_r;
  logic               de_fall;
  logic [COORD_W-1:0] x_reg, y_reg;
  logic [COORD_W-1:0] xmin_reg, xmax_reg, ymin_reg, ymax_reg;

  assign de_fall = de_r & ~i_de;

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      de_r  <= 1'b0;
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      de_r <= i_de;
      if (de_fall) begin
        x_reg <= '0;
      end else if (i_de && (x_reg != X_LAST)) begin
        x_reg <= x_reg + COORD_W'(1);
      end
      if (acc_state_reg == ACC_WAIT) begin
        y_reg <= '0;
      end else if (de_fall && (y_reg != Y_LAST)) begin
        y_reg <= y_reg + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      xmin_reg <= '0;
      xmax_reg <= '0;
      ymin_reg <= '0;
      ymax_reg <= '0;
    end else if (acc_clear) begin
      xmin_reg <= '1;
      xmax_reg <= '0;
      ymin_reg <= '1;
      ymax_reg <= '0;
    end else if (pix) begin
      if (x_reg < xmin_reg) xmin_reg <= x_reg;
      if (x_reg > xmax_reg) xmax_reg <= x_reg;
      if (y_reg < ymin_reg) ymin_reg <= y_reg;
      if (y_reg > ymax_reg) ymax_reg <= y_reg;
    end
  end
`else
  // Frame geometry only matters to the bbox trackers.
  logic unused_geom;
  assign unused_geom = ^{H_ACT[0], V_ACT[0]};
  assign o_xmin = '0;
  assign o_xmax = '0;
  assign o_ymin = '0;
  assign o_ymax = '0;
`endif

  stats_normalizer #(
    .CW (CW),
    .SW (SW),
    .N  (N)
  ) u_norm (
    .pixelclk     (pixelclk),
    .rst_n        (rst_n),
    .start        (nrm_start),
    .snap_count   (count_reg),
    .snap_sum     (sum_reg),
`ifdef STATS_BBOX_EN
    .snap_xmin    (xmin_reg),
    .snap_xmax    (xmax_reg),
    .snap_ymin    (ymin_reg),
    .snap_ymax    (ymax_reg),
    .o_xmin       (o_xmin),
    .o_xmax       (o_xmax),
    .o_ymin       (o_ymin),
    .o_ymax       (o_ymax),
`endif
    .busy         (nrm_busy),
    .o_dividend   (o_dividend),
    .o_divisor    (o_divisor),
    .o_shift      (o_shift),
    .o_count      (o_count),
    .o_empty      (o_empty),
    .o_stat_valid (o_stat_valid)
  );

endmodule

// File: tb/tb_frame_mask_stats.sv
// Directed bench for frame_mask_stats: table of small frames, reset/overrun
// sequences, and a normaliser table for full-size 640x480 operands.
module tb_frame_mask_stats;

  localparam int CW      = 20;
  localparam int SW      = 28;
  localparam int N       = 16;
  localparam int LAT     = SW - N + 3;
  localparam int MAX_LAT = SW - N + 2;
`ifdef STATS_BBOX_EN
  localparam bit BBOX = 1'b1;
`else
  localparam bit BBOX = 1'b0;
`endif

  logic        pixelclk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        i_hs     = 1'b0;
  logic        i_vs     = 1'b0;
  logic        i_de     = 1'b0;
  logic        i_mask   = 1'b0;
  logic [7:0]  i_value  = 8'd0;
  logic [N-1:0]  o_dividend, o_divisor;
  logic [4:0]    o_shift;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic [11:0]   o_xmin, o_xmax, o_ymin, o_ymax;
  logic          o_stat_valid, o_overrun, o_hsync, o_vsync, o_de;

  logic          n_start = 1'b0;
  logic [CW-1:0] n_snap_count = '0;
  logic [SW-1:0] n_snap_sum = '0;
  logic          n_busy;
  logic [N-1:0]  n_dividend, n_divisor;
  logic [4:0]    n_shift;
  logic [CW-1:0] n_count;
  logic          n_empty;
  logic          n_valid;
`ifdef STATS_BBOX_EN
  logic [11:0]   n_xmin, n_xmax, n_ymin, n_ymax;
`endif

  always #5 pixelclk = ~pixelclk;

  frame_mask_stats dut (
    .pixelclk(pixelclk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_mask(i_mask), .i_value(i_value), .o_dividend(o_dividend), .o_divisor(o_divisor),
    .o_shift(o_shift), .o_count(o_count), .o_empty(o_empty), .o_xmin(o_xmin),
    .o_xmax(o_xmax), .o_ymin(o_ymin), .o_ymax(o_ymax), .o_stat_valid(o_stat_valid),
    .o_overrun(o_overrun), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de)
  );

  stats_normalizer #(.CW(CW), .SW(SW), .N(N)) nrm (
    .pixelclk(pixelclk), .rst_n(rst_n), .start(n_start),
    .snap_count(n_snap_count), .snap_sum(n_snap_sum),
`ifdef STATS_BBOX_EN
    .snap_xmin(12'd0), .snap_xmax(12'd0), .snap_ymin(12'd0), .snap_ymax(12'd0),
    .o_xmin(n_xmin), .o_xmax(n_xmax), .o_ymin(n_ymin), .o_ymax(n_ymax),
`endif
    .busy(n_busy), .o_dividend(n_dividend), .o_divisor(n_divisor), .o_shift(n_shift),
    .o_count(n_count), .o_empty(n_empty), .o_stat_valid(n_valid)
  );

  typedef struct {
    int w; int h; int mode; int px; int py; int val;
    longint e_count; longint e_div; longint e_dvs; longint e_shift; longint e_empty;
    longint e_xmin; longint e_xmax; longint e_ymin; longint e_ymax;
  } vec_t;

  typedef struct {
    longint sum; longint count; longint e_div; longint e_dvs; longint e_shift;
  } nvec_t;

  vec_t  vecs [5];
  nvec_t nvecs[4];

  int checks = 0;
  int errors = 0;

  int cyc = 0, valid_cnt = 0, ovr_cnt = 0, de_cnt = 0;
  int valid_cyc = 0, vsfall_cyc = 0, infall_cyc = 0;
  logic vs_d = 1'b0, ivs_d = 1'b0;
  logic [N-1:0]  cap_div, cap_dvs;
  logic [4:0]    cap_shift;
  logic [CW-1:0] cap_count;
  logic          cap_empty;
  logic [11:0]   cap_xmin, cap_xmax, cap_ymin, cap_ymax;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pixelclk);
      #1;
    end
  endtask

  // mode 0: all foreground, 1: none, 2: single pixel at (px,py)
  task automatic run_frame(input int w, input int h, input int mode, input int px,
                           input int py, input int val, input bit glitch, input int vblank);
    i_vs = 1'b1;
    tick(3);
    for (int y = 0; y < h; y++) begin
      i_hs = 1'b1; tick(2); i_hs = 1'b0; tick(2);
      for (int x = 0; x < w; x++) begin
        i_de    = 1'b1;
        i_value = 8'(val);
        i_mask  = (mode == 0) || (mode == 2 && x == px && y == py);
        tick(1);
      end
      i_de = 1'b0; i_mask = 1'b0; i_value = 8'd0;
      tick(3);
    end
    i_vs = 1'b0;
    if (glitch) begin
      tick(1); i_vs = 1'b1; tick(1); i_vs = 1'b0;
    end
    tick(vblank);
  endtask

  initial begin
    forever begin
      @(negedge pixelclk);
      if (o_stat_valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        cap_div = o_dividend; cap_dvs = o_divisor; cap_shift = o_shift;
        cap_count = o_count; cap_empty = o_empty;
        cap_xmin = o_xmin; cap_xmax = o_xmax; cap_ymin = o_ymin; cap_ymax = o_ymax;
      end
      if (o_overrun) ovr_cnt++;
      if (o_de) de_cnt++;
      if (vs_d && !o_vsync) vsfall_cyc = cyc;
      if (ivs_d && !i_vs) infall_cyc = cyc;
      vs_d  = o_vsync;
      ivs_d = i_vs;
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int v0, d0, o0, lat;

    vecs[0] = '{8,   4, 0, 0, 0, 10,  32,  320,   32, 0, 0, 0, 7,  0, 3};
    vecs[1] = '{8,   4, 1, 0, 0, 10,  0,   0,     0,  0, 1, 0, 0,  0, 0};
    vecs[2] = '{8,   4, 2, 3, 2, 200, 1,   200,   1,  0, 0, 3, 3,  2, 2};
    vecs[3] = '{100, 4, 0, 0, 0, 255, 400, 51000, 200, 1, 0, 0, 99, 0, 3};
    vecs[4] = '{16,  2, 0, 0, 0, 7,   32,  224,   32, 0, 0, 0, 15, 0, 1};

    nvecs[0] = '{78336000,     307200,      38250, 150,   11};
    nvecs[1] = '{268435455,    1048575,     65535, 255,   12};
    nvecs[2] = '{0,            70000,       0,     65535, 0};
    nvecs[3] = '{1048576,      1,           32768, 1,     5};

    // Power-up reset held mid-frame, then released before the frame ends.
    rst_n = 1'b0; i_vs = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_de = k[0]; i_mask = 1'b1; i_value = 8'd99;
      tick(1);
    end
    check("rst0_dividend", o_dividend, 0);
    check("rst0_divisor", o_divisor, 0);
    check("rst0_count", o_count, 0);
    check("rst0_valid", o_stat_valid, 0);
    check("rst0_vsync", o_vsync, 0);
    rst_n = 1'b1; i_de = 1'b1; tick(4);
    i_de = 1'b0; tick(2);
    i_vs = 1'b0; i_mask = 1'b0; tick(24);
    check("partial_frame_no_valid", valid_cnt, 0);

    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt; d0 = de_cnt;
      run_frame(vecs[i].w, vecs[i].h, vecs[i].mode, vecs[i].px, vecs[i].py, vecs[i].val, 1'b0, 24);
      check($sformatf("v%0d_valid_pulses", i), valid_cnt - v0, 1);
      check($sformatf("v%0d_count", i), cap_count, vecs[i].e_count);
      check($sformatf("v%0d_dividend", i), cap_div, vecs[i].e_div);
      check($sformatf("v%0d_divisor", i), cap_dvs, vecs[i].e_dvs);
      check($sformatf("v%0d_shift", i), cap_shift, vecs[i].e_shift);
      check($sformatf("v%0d_empty", i), cap_empty, vecs[i].e_empty);
      check($sformatf("v%0d_xmin", i), cap_xmin, BBOX ? vecs[i].e_xmin : 0);
      check($sformatf("v%0d_xmax", i), cap_xmax, BBOX ? vecs[i].e_xmax : 0);
      check($sformatf("v%0d_ymin", i), cap_ymin, BBOX ? vecs[i].e_ymin : 0);
      check($sformatf("v%0d_ymax", i), cap_ymax, BBOX ? vecs[i].e_ymax : 0);
      check($sformatf("v%0d_held_dividend", i), o_dividend, vecs[i].e_div);
      check($sformatf("v%0d_de_delayed", i), de_cnt - d0, vecs[i].w * vecs[i].h);
      check($sformatf("v%0d_vsync_delay", i), vsfall_cyc - infall_cyc, LAT);
      check($sformatf("v%0d_valid_latency_ok", i),
            (valid_cyc > infall_cyc) && (valid_cyc - infall_cyc <= MAX_LAT), 1);
      check($sformatf("v%0d_valid_before_vsync_fall", i), valid_cyc < vsfall_cyc, 1);
    end

    // Reset held 5 cycles in the middle of a frame with live outputs.
    v0 = valid_cnt;
    i_vs = 1'b1; tick(3);
    i_de = 1'b1; i_mask = 1'b1; i_value = 8'd50; tick(3);
    rst_n = 1'b0; tick(5);
    check("rst1_dividend", o_dividend, 0);
    check("rst1_divisor", o_divisor, 0);
    check("rst1_shift", o_shift, 0);
    check("rst1_count", o_count, 0);
    check("rst1_empty", o_empty, 0);
    check("rst1_bbox", {o_xmin, o_xmax, o_ymin, o_ymax}, 0);
    check("rst1_valid", o_stat_valid, 0);
    check("rst1_overrun", o_overrun, 0);
    check("rst1_syncs", {o_hsync, o_vsync, o_de}, 0);
    rst_n = 1'b1; tick(3);
    i_de = 1'b0; i_mask = 1'b0; tick(3);
    i_vs = 1'b0; tick(24);
    check("rst1_first_fall_no_valid", valid_cnt - v0, 0);
    run_frame(8, 4, 0, 0, 0, 10, 1'b0, 24);
    check("rst1_next_valid_pulses", valid_cnt - v0, 1);
    check("rst1_next_count", cap_count, 32);
    check("rst1_next_dividend", cap_div, 320);

    // Shortened VS blank: second snapshot lands while the first is still normalising.
    v0 = valid_cnt; o0 = ovr_cnt;
    run_frame(100, 4, 0, 0, 0, 255, 1'b1, 30);
    check("ovr_overrun_pulses", ovr_cnt - o0, 1);
    check("ovr_valid_pulses", valid_cnt - v0, 1);
    check("ovr_dividend", o_dividend, 51000);
    check("ovr_divisor", o_divisor, 200);
    check("ovr_shift", o_shift, 1);
    check("ovr_count", o_count, 400);
    v0 = valid_cnt;
    run_frame(8, 4, 2, 3, 2, 200, 1'b0, 24);
    check("post_ovr_valid_pulses", valid_cnt - v0, 1);
    check("post_ovr_count", cap_count, 1);
    check("post_ovr_dividend", cap_div, 200);

    // Full-size operands straight into the normaliser.
    for (int i = 0; i < 4; i++) begin
      n_snap_sum = SW'(nvecs[i].sum);
      n_snap_count = CW'(nvecs[i].count);
      n_start = 1'b1;
      tick(1);
      n_start = 1'b0;
      lat = 1;
      while (!n_valid && lat < 40) begin
        tick(1);
        lat++;
      end
      check($sformatf("n%0d_valid_seen", i), n_valid, 1);
      check($sformatf("n%0d_latency_ok", i), lat <= MAX_LAT, 1);
      check($sformatf("n%0d_dividend", i), n_dividend, nvecs[i].e_div);
      check($sformatf("n%0d_divisor", i), n_divisor, nvecs[i].e_dvs);
      check($sformatf("n%0d_shift", i), n_shift, nvecs[i].e_shift);
      check($sformatf("n%0d_count", i), n_count, nvecs[i].count);
      check($sformatf("n%0d_empty", i), n_empty, 0);
      tick(3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_mask_stats.md
Name: frame_mask_stats

Overview:
- Per-frame statistics stage that sits directly upstream of the frame-end divider.
- Accumulates, over each video frame, the count of foreground (mask=1) pixels and the sum of their feature values (e.g. hue). It optionally tracks the foreground bounding box.
- At frame end it normalises sum and count to N bits and presents them as dividend/divisor, held stable until the next frame end.
- Sync outputs are delayed so the downstream divider's VS-fall trigger always samples settled operands.

Parameters:
- H_ACT, 640, active pixels per line (x-counter clamp)
- V_ACT, 480, active lines per frame (y-counter clamp)
- DW, 8, feature value width
- CW, 20, pixel-count accumulator width
- SW, 28, sum accumulator width (SW > N)
- N, 16, output operand width (matches divider)

Ports:
- pixelclk  in  1  pixel clock
- rst_n  in  1  reset
- i_hs  in  1  line sync
- i_vs  in  1  frame sync, high during frame; falling edge = frame end
- i_de  in  1  data enable
- i_mask  in  1  foreground flag, qualified by i_de
- i_value  in  DW  feature value, qualified by i_de & i_mask
- o_dividend  out  N  normalised sum
- o_divisor  out  N  normalised count
- o_shift  out  5  right-shift applied in normalisation
- o_count  out  CW  raw foreground count of last frame
- o_empty  out  1  last frame had zero foreground pixels
- o_xmin, o_xmax, o_ymin, o_ymax  out  12 each  bounding box of last frame
- o_stat_valid  out  1  one-cycle pulse when outputs update
- o_overrun  out  1  one-cycle pulse when a snapshot is dropped
- o_hsync, o_vsync, o_de  out  1 each  i_hs/i_vs/i_de delayed LAT = SW-N+3 cycles

Behaviour:
- Reset: rst_n, synchronous, active-low; clock pixelclk. All outputs, accumulators, counters and delay lines go to 0; accumulate FSM enters SYNC, normalise FSM enters IDLE. Reset mid-operation aborts everything.
- VS edge detect: register vs_r; rise = i_vs & !vs_r; fall = !i_vs & vs_r.
- Accumulate FSM:
  - SYNC: discards the partial frame after reset; on the first fall goes to WAIT with no snapshot.
  - WAIT: accumulators cleared; on rise goes to ACTIVE.
  - ACTIVE: accumulates; on fall takes a snapshot (count, sum, bbox into shadow registers), clears the accumulators in the same cycle, and goes to WAIT.
- x/y counters:
  - x increments on each i_de cycle and resets on i_de falling.
  - y increments on i_de falling and resets in WAIT.
  - x saturates at H_ACT-1 and y saturates at V_ACT-1.
- Accumulation, per i_de & i_mask cycle:
  - count += 1, saturating at 2^CW-1.
  - sum += i_value, saturating at 2^SW-1.
  - bbox min/max update. Initial values: min = all-ones, max = 0.
- Normalise FSM:
  - IDLE: on snapshot, loads shadow sum/count and sets shift=0, then goes to NORM.
  - NORM: one step per cycle. If sum < 2^N, go to LATCH; otherwise sum>>=1, count>>=1, shift+=1. Worst case SW-N cycles.
  - LATCH: o_dividend = sum[N-1:0]; o_divisor = count, saturated to 2^N-1, and forced to 1 if it reached 0 after shifting while the raw count is nonzero. Also updates o_shift, o_count, o_empty (raw count==0) and the bbox outputs. Pulses o_stat_valid for one cycle, then returns to IDLE.
- Empty frame: dividend = divisor = 0, o_empty=1, bbox all 0. Downstream handles divisor 0.
- Snapshot arriving while the normalise FSM is not IDLE: the new snapshot is dropped and o_overrun pulses. The old result completes.
- Latency: o_stat_valid rises at most SW-N+2 cycles after fall is detected. Outputs are therefore stable at least one cycle before o_vsync falls.
- Outputs hold their value until the next LATCH.

Optional Feature:
- Macro STATS_BBOX_EN.
- Defined: bounding-box trackers and shadows are built; o_xmin/o_xmax/o_ymin/o_ymax are driven as above.
- Undefined: bbox logic is removed and the four outputs are tied to 0. Count, sum, normalise and sync paths are unchanged.

Decomposition:
- Shared package holds:
  - FSM state encodings: SYNC/WAIT/ACTIVE and IDLE/NORM/LATCH, one-hot.
  - LAT = SW-N+3.
  - Coordinate width 12.
- Natural sub-module: stats_normalizer. It contains the NORM shift loop and the LATCH output registers, with snapshot inputs and start/busy handshake.

Test Plan:
- Reset held 5 cycles mid-frame -> all outputs 0. Release mid-frame -> no o_stat_valid at the first VS fall; first pulse comes after the next full frame.
- H_ACT=8, V_ACT=4, all mask=1, value=10 -> count 32, dividend 320, divisor 32, shift 0, bbox 0/7/0/3, exactly one valid pulse per frame.
- Same frame with mask=0 -> o_empty=1, dividend 0, divisor 0, bbox 0.
- Single pixel at x=3, y=2, value 200 -> count 1, dividend 200, divisor 1, bbox 3/3/2/2.
- 640x480, all mask=1, value=255 -> sum 78336000, shift 11, dividend 38250, divisor 150, o_count 307200. Valid arrives before the o_vsync fall.
- Force a second snapshot during NORM, using a shortened VS blank -> o_overrun pulses once and the first result is latched unchanged.
